// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared types and constants for the class control-request engine
package control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXEC_SET = 3'd2,
    ST_EXEC_GET = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [7:0]  DEF_SET_REQ     = 8'h03;
  localparam logic [7:0]  DEF_GET_REQ     = 8'h83;
  localparam logic [15:0] DEF_BLOCK_BYTES = 16'd12;

  localparam logic [1:0]  RT_TYPE_CLASS   = 2'b01;
  localparam logic [4:0]  RT_RCPT_IFACE   = 5'b00001;

  localparam int SETUP_RT_LSB  = 56;
  localparam int SETUP_REQ_LSB = 48;
  localparam int SETUP_VAL_LSB = 32;
  localparam int SETUP_IDX_LSB = 16;
  localparam int SETUP_LEN_LSB = 0;

  // Clamp a requested transfer length to the size of the parameter blocks.
  function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] lim);
    return (len > lim) ? lim : len;
  endfunction

  // Cycles busy stays high after the accepting edge, minus one.
  localparam logic [1:0] BUSY_HOLD = 2'd2;

endpackage

// File: rtl/control_setup_decode.sv
// rtl/control_setup_decode.sv - classifies a captured SETUP packet and clamps its length
module control_setup_decode
  import control_pkg::*;
#(
  parameter logic [7:0]  SET_REQ     = DEF_SET_REQ,
  parameter logic [7:0]  GET_REQ     = DEF_GET_REQ,
  parameter logic [15:0] BLOCK_BYTES = DEF_BLOCK_BYTES
) (
  input  logic [63:0] i_setup,
  output logic        o_is_set,
  output logic        o_is_get,
  output logic [15:0] o_len_clamped
);

  logic [7:0]  w_rtype;
  logic [7:0]  w_breq;
  logic [15:0] w_wlen;
  logic        w_class_iface;
  logic        w_unused_fields;

  assign w_rtype = i_setup[SETUP_RT_LSB +: 8];
  assign w_breq  = i_setup[SETUP_REQ_LSB +: 8];
  assign w_wlen  = i_setup[SETUP_LEN_LSB +: 16];

  // wValue and wIndex carry no meaning for these requests.
  assign w_unused_fields = ^{i_setup[SETUP_VAL_LSB +: 16], i_setup[SETUP_IDX_LSB +: 16]};

  assign w_class_iface = (w_rtype[6:5] == RT_TYPE_CLASS) && (w_rtype[4:0] == RT_RCPT_IFACE);

  assign o_is_set      = w_class_iface && !w_rtype[7] && (w_breq == SET_REQ);
  assign o_is_get      = w_class_iface &&  w_rtype[7] && (w_breq == GET_REQ);
  assign o_len_clamped = clamp_len(w_wlen, BLOCK_BYTES);

endmodule

// File: rtl/control_block.sv
// rtl/control_block.sv - class control-request engine: SETUP capture, SET/GET execution, storage
module control_block
  import control_pkg::*;
#(
  parameter logic [7:0]  SET_REQ     = DEF_SET_REQ,
  parameter logic [7:0]  GET_REQ     = DEF_GET_REQ,
  parameter logic [15:0] BLOCK_BYTES = DEF_BLOCK_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] data,
  input  logic [31:0] parameter_Block32,
  input  logic [63:0] parameter_Block64,
  output logic        busy,
  output logic [31:0] data_out32,
  output logic [63:0] data_out64,
  output logic [15:0] data_out16
);

  state_t      r_state;
  logic [63:0] r_setup;
  logic [31:0] r_stored32;
  logic [63:0] r_stored64;
  logic [1:0]  r_busy_cnt;

  logic        w_is_set;
  logic        w_is_get;
  logic [15:0] w_len_clamped;

  control_setup_decode #(
    .SET_REQ     (SET_REQ),
    .GET_REQ     (GET_REQ),
    .BLOCK_BYTES (BLOCK_BYTES)
  ) u_decode (
    .i_setup       (r_setup),
    .o_is_set      (w_is_set),
    .o_is_get      (w_is_get),
    .o_len_clamped (w_len_clamped)
  );

  // busy is a fixed three-cycle window per request so that unsupported
  // requests (which skip EXEC) present the same timing as valid ones; a new
  // request is only taken once the window has closed, giving one per 4 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_setup    <= '0;
      r_stored32 <= '0;
      r_stored64 <= '0;
      r_busy_cnt <= '0;
      busy       <= 1'b0;
      data_out32 <= '0;
      data_out64 <= '0;
      data_out16 <= '0;
    end else begin
      if (busy) begin
        if (r_busy_cnt == 2'd0) begin
          busy <= 1'b0;
        end else begin
          r_busy_cnt <= r_busy_cnt - 2'd1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (enable && !busy) begin
            r_setup    <= data;
            r_state    <= ST_DECODE;
            busy       <= 1'b1;
            r_busy_cnt <= BUSY_HOLD;
          end
        end
        ST_DECODE: begin
          if (w_is_set) begin
            r_state <= ST_EXEC_SET;
          end else if (w_is_get) begin
            r_state <= ST_EXEC_GET;
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_EXEC_SET: begin
          r_stored32 <= parameter_Block32;
          r_stored64 <= parameter_Block64;
          data_out16 <= w_len_clamped;
          r_state    <= ST_DONE;
        end
        ST_EXEC_GET: begin
          data_out32 <= r_stored32;
          data_out64 <= r_stored64;
          data_out16 <= w_len_clamped;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_block.sv
// tb/tb_control_block.sv - directed self-checking bench for control_block
module tb_control_block;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [63:0] data;
  logic [31:0] parameter_Block32;
  logic [63:0] parameter_Block64;
  logic        busy;
  logic [31:0] data_out32;
  logic [63:0] data_out64;
  logic [15:0] data_out16;

  int total;
  int bad;

  control_block dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .data              (data),
    .parameter_Block32 (parameter_Block32),
    .parameter_Block64 (parameter_Block64),
    .busy              (busy),
    .data_out32        (data_out32),
    .data_out64        (data_out64),
    .data_out16        (data_out16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] e32, input logic [63:0] e64,
                          input logic [15:0] e16);
    chk({tag, ".out32"}, {32'h0, data_out32}, {32'h0, e32});
    chk({tag, ".out64"}, data_out64, e64);
    chk({tag, ".out16"}, {48'h0, data_out16}, {48'h0, e16});
  endtask

  // One-cycle enable strobe, then expect busy for exactly three cycles.
  task automatic request(input string tag, input logic [63:0] pkt);
    data   = pkt;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    data   = 64'hDEAD_BEEF_CAFE_F00D;
    chk({tag, ".busy0"}, {63'h0, busy}, 64'h1);
    tick();
    chk({tag, ".busy1"}, {63'h0, busy}, 64'h1);
    tick();
    chk({tag, ".busy2"}, {63'h0, busy}, 64'h1);
    tick();
    chk({tag, ".busy_fall"}, {63'h0, busy}, 64'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    enable = 1'b1;
    data  = {8'h21, 8'h03, 16'h0, 16'h0, 16'd2};
    parameter_Block32 = 32'h5555_5555;
    parameter_Block64 = 64'hAAAA_AAAA_AAAA_AAAA;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.busy", {63'h0, busy}, 64'h0);
      chk_outs("rst", 32'h0, 64'h0, 16'h0);
    end
    rst    = 1'b0;
    enable = 1'b0;
    tick();
    chk("post_rst.busy", {63'h0, busy}, 64'h0);
    chk_outs("post_rst", 32'h0, 64'h0, 16'h0);

    parameter_Block32 = 32'd1;
    parameter_Block64 = 64'd12;
    request("set", {8'h21, 8'h03, 16'h0, 16'h0, 16'd2});
    chk_outs("set", 32'h0, 64'h0, 16'd2);

    parameter_Block64 = 64'd0;
    request("get", {8'hA1, 8'h83, 16'h0, 16'h0, 16'd2});
    chk_outs("get", 32'd1, 64'd12, 16'd2);

    request("get_clamp", {8'hA1, 8'h83, 16'h1234, 16'h0001, 16'd100});
    chk_outs("get_clamp", 32'd1, 64'd12, 16'd12);

    request("get_len12", {8'hA1, 8'h83, 16'h0, 16'h0, 16'd12});
    chk_outs("get_len12", 32'd1, 64'd12, 16'd12);

    request("get_len0", {8'hA1, 8'h83, 16'h0, 16'h0, 16'd0});
    chk_outs("get_len0", 32'd1, 64'd12, 16'd0);

    parameter_Block32 = 32'h7777_0000;
    parameter_Block64 = 64'h1111_2222_3333_4444;
    request("unsup_dir", {8'h21, 8'h83, 16'h0, 16'h0, 16'd5});
    chk_outs("unsup_dir", 32'd1, 64'd12, 16'd0);
    request("unsup_type", {8'hC0, 8'h03, 16'h0, 16'h0, 16'd7});
    chk_outs("unsup_type", 32'd1, 64'd12, 16'd0);
    request("unsup_get", {8'hA1, 8'h83, 16'h0, 16'h0, 16'd3});
    chk_outs("unsup_get", 32'd1, 64'd12, 16'd3);

    // Abort a SET while it is in EXEC_SET.
    parameter_Block32 = 32'd5;
    parameter_Block64 = 64'd6;
    data   = {8'h21, 8'h03, 16'h0, 16'h0, 16'd8};
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.busy", {63'h0, busy}, 64'h0);
    chk_outs("midrst", 32'h0, 64'h0, 16'h0);
    request("get_after_rst", {8'hA1, 8'h83, 16'h0, 16'h0, 16'd4});
    chk_outs("get_after_rst", 32'h0, 64'h0, 16'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
